// File: rtl/pipeline_foreground_fetch.sv
// Foreground pixel fetch stage: turns foreground coordinates into SRAM reads
// and returns one colour per input pixel, strictly in input order. Inactive or
// out-of-frame pixels bypass the SRAM and come out as zero.
module pipeline_foreground_fetch #(
   parameter int RESOLUTION_X = 640,
   parameter int RESOLUTION_Y = 480,
   parameter int ADDR_WIDTH   = 19,
   parameter int PIXEL_WIDTH  = 12,
   parameter int DEPTH        = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [9:0]             fg_pixel_x,
   input  logic [9:0]             fg_pixel_y,
   input  logic                   fg_active,
   output logic                   mem_req,
   output logic [ADDR_WIDTH-1:0]  mem_addr,
   input  logic                   mem_ack,
   input  logic                   mem_rvalid,
   input  logic [PIXEL_WIDTH-1:0] mem_rdata,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [PIXEL_WIDTH-1:0] out_pixel,
   output logic                   out_active
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [31:0]      RES_X   = RESOLUTION_X;
   localparam logic [31:0]      RES_Y   = RESOLUTION_Y;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   // Reorder buffer: one entry per accepted pixel, in input order
   logic                   buf_active_q [DEPTH];
   logic                   buf_filled_q [DEPTH];
   logic [PIXEL_WIDTH-1:0] buf_data_q   [DEPTH];

   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  mem_req_q, mem_req_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;

   logic                  eff_active;
   logic [ADDR_WIDTH-1:0] addr_calc;
   logic                  push;
   logic                  pop;
   logic                  fill;
   logic                  fill_found;
   logic [PTR_W-1:0]      fill_idx;
   logic [PTR_W-1:0]      scan_idx;

   // Out-of-frame coordinates (upstream shift overflow) never touch the SRAM.
   assign eff_active = fg_active && (32'(fg_pixel_x) < RES_X) && (32'(fg_pixel_y) < RES_Y);
   // Modular arithmetic at ADDR_WIDTH equals the full-width result truncated.
   assign addr_calc  = ADDR_WIDTH'(fg_pixel_y) * ADDR_WIDTH'(RESOLUTION_X) + ADDR_WIDTH'(fg_pixel_x);

   // A pending unacknowledged request blocks new input: the request slot is single.
   assign in_ready   = !rst && (count_q < DEPTH_C) && !(mem_req_q && !mem_ack);
   assign push       = in_valid && in_ready;
   assign out_valid  = (count_q != '0) && buf_filled_q[rd_ptr_q];
   assign out_pixel  = buf_data_q[rd_ptr_q];
   assign out_active = buf_active_q[rd_ptr_q];
   assign pop        = out_valid && out_ready;
   assign fill       = mem_rvalid && fill_found;
   assign mem_req    = mem_req_q;
   assign mem_addr   = mem_addr_q;

   // Locate the oldest active entry still waiting for data; inactive entries are skipped
   always_comb begin
      fill_found = 1'b0;
      fill_idx   = '0;
      scan_idx   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         scan_idx = rd_ptr_q + PTR_W'(i);
         if (!fill_found && (CNT_W'(i) < count_q) &&
             buf_active_q[scan_idx] && !buf_filled_q[scan_idx]) begin
            fill_found = 1'b1;
            fill_idx   = scan_idx;
         end
      end
   end

   // Next-state for pointers, occupancy and the request slot
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      mem_req_d  = mem_req_q;
      mem_addr_d = mem_addr_q;
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push && !pop)      count_d = count_q + CNT_ONE;
      else if (!push && pop) count_d = count_q - CNT_ONE;
      // A new active accept in the ack cycle reloads the slot and keeps mem_req high.
      if (push && eff_active) begin
         mem_req_d  = 1'b1;
         mem_addr_d = addr_calc;
      end else if (mem_ack) begin
         mem_req_d  = 1'b0;
      end
   end

   // Pointer, count and request-slot registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         mem_req_q  <= 1'b0;
         mem_addr_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         mem_req_q  <= mem_req_d;
         mem_addr_q <= mem_addr_d;
      end
   end

   // Buffer entries: push a new pixel at the write pointer, fill returned data in order
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            buf_active_q[i] <= 1'b0;
            buf_filled_q[i] <= 1'b0;
            buf_data_q[i]   <= '0;
         end
      end else begin
         // Push slot is always free and fill targets an occupied entry, so they never collide.
         if (push) begin
            buf_active_q[wr_ptr_q] <= eff_active;
            buf_filled_q[wr_ptr_q] <= !eff_active;
            buf_data_q[wr_ptr_q]   <= '0;
         end
         if (fill) begin
            buf_filled_q[fill_idx] <= 1'b1;
            buf_data_q[fill_idx]   <= mem_rdata;
         end
      end
   end

endmodule
